data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: DataMemory

---
 rtl/data_memory.sv | 55 +++++
 tb/tb_data_memory.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory with 4-lane vector or scalar access.
// Reads are combinational. Writes happen on the rising clock edge. Reset clears every word asynchronously.
module data_memory #(
  parameter int DEPTH = 16384
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         vf,
  input  logic [127:0] addr,
  input  logic [127:0] wd,
  output logic [127:0] rd
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] w_base;
  logic [AW-1:0] w_idx [4];
  logic          w_unused_addr;

  assign w_base        = addr[AW-1:0];
  assign w_unused_addr = ^addr[127:AW];

  // Lane indices wrap naturally because they are truncated to AW bits.
  for (genvar g = 0; g < 4; g++) begin : g_lane_idx
    assign w_idx[g] = w_base + AW'(g);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[w_idx[0]] <= wd[31:0];
      if (vf) begin
        for (int i = 1; i < 4; i++) begin
          r_mem[w_idx[i]] <= wd[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    rd       = '0;
    rd[31:0] = r_mem[w_idx[0]];
    if (vf) begin
      for (int i = 1; i < 4; i++) begin
        rd[32*i +: 32] = r_mem[w_idx[i]];
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// A reference word array produces the expected read data. Expected values are queued and then compared against rd.
module tb_data_memory;

  localparam int DEPTH = 16384;
  localparam int AW    = 14;

  logic         clk;
  logic         rst;
  logic         we;
  logic         vf;
  logic [127:0] addr;
  logic [127:0] wd;
  logic [127:0] rd;

  logic [31:0]  m_mem [DEPTH];
  logic [127:0] sb [$];
  logic [127:0] exp_v;
  int           checks;
  int           failures;

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .vf   (vf),
    .addr (addr),
    .wd   (wd),
    .rd   (rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] model_read(input logic [127:0] a, input logic v);
    logic [127:0] r;
    int           base;
    base     = int'(a[AW-1:0]);
    r        = '0;
    r[31:0]  = m_mem[base];
    if (v) begin
      for (int i = 1; i < 4; i++) r[32*i +: 32] = m_mem[(base + i) % DEPTH];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // Presents one write and holds it across one rising edge. The reference array follows only when reset is high.
  task automatic do_write(input logic [127:0] a, input logic v, input logic [127:0] d);
    int base;
    @(negedge clk);
    addr = a; vf = v; wd = d; we = 1'b1;
    @(posedge clk);
    if (rst) begin
      base = int'(a[AW-1:0]);
      m_mem[base] = d[31:0];
      if (v) for (int i = 1; i < 4; i++) m_mem[(base + i) % DEPTH] = d[32*i +: 32];
    end
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [127:0] a_list [4];
    a_list[0] = 128'd0; a_list[1] = 128'd10000; a_list[2] = 128'(DEPTH - 2); a_list[3] = 128'd1 << 60;
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 2; m++) begin
        addr = a_list[i]; vf = m[0];
        sb.push_back(128'd0);
        #1;
        exp_v = sb.pop_front();
        checks++;
        if (rd !== exp_v) begin
          failures++;
          $display("FAIL reset_read addr=%0h vf=%0d got=%h exp=%h", addr, vf, rd, exp_v);
        end
      end
    end
  endtask

  task automatic test_vector();
    @(negedge clk);
    addr = 128'd0; vf = 1'b1; wd = {32'd4, 32'd3, 32'd2, 32'd1}; we = 1'b1;
    sb.push_back(128'd0);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL vec_rdw_old got=%h exp=%h", rd, exp_v);
    end
    @(posedge clk);
    m_mem[0] = 32'd1; m_mem[1] = 32'd2; m_mem[2] = 32'd3; m_mem[3] = 32'd4;
    #1;
    we = 1'b0;
    sb.push_back({32'd4, 32'd3, 32'd2, 32'd1});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL vec_read got=%h exp=%h", rd, exp_v);
    end
  endtask

  task automatic test_scalar();
    do_write(128'd10000, 1'b0, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'd1});
    addr = 128'd10000; vf = 1'b0;
    sb.push_back({96'd0, 32'd1});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL scalar_read got=%h exp=%h", rd, exp_v);
    end
    vf = 1'b1;
    sb.push_back({32'd0, 32'd0, 32'd0, 32'd1});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL scalar_neighbours got=%h exp=%h", rd, exp_v);
    end
  endtask

  task automatic test_scalar_of_vector();
    addr = 128'd2; vf = 1'b0;
    sb.push_back({96'd0, 32'd3});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL scalar_of_vector got=%h exp=%h", rd, exp_v);
    end
  endtask

  task automatic test_wrap();
    do_write(128'(DEPTH - 2), 1'b1, {32'd8, 32'd7, 32'd6, 32'd5});
    addr = 128'(DEPTH - 2) + (128'd1 << 40); vf = 1'b1;
    sb.push_back({32'd8, 32'd7, 32'd6, 32'd5});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL wrap_read_hi got=%h exp=%h", rd, exp_v);
    end
    addr = 128'd0;
    sb.push_back({32'd4, 32'd3, 32'd8, 32'd7});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL wrap_low_words got=%h exp=%h", rd, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a_hist [8];
    logic         v_hist [8];
    for (int i = 0; i < 8; i++) begin
      a_hist[i] = {$urandom, $urandom, $urandom, 32'(5000 + $urandom_range(0, 12))};
      v_hist[i] = 1'($urandom_range(0, 1));
      do_write(a_hist[i], v_hist[i], {$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i < 8; i++) begin
      addr = a_hist[i]; vf = 1'b1;
      sb.push_back(model_read(a_hist[i], 1'b1));
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (rd !== exp_v) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h exp=%h", i, rd, exp_v);
      end
    end
  endtask

  task automatic test_write_disable();
    logic [127:0] a_list [4];
    @(negedge clk);
    we = 1'b0; wd = '1;
    for (int i = 0; i < 4; i++) begin
      addr = 128'd0; vf = 1'b1;
      #2 we = 1'b1;
      #1 we = 1'b0;
      @(negedge clk);
    end
    a_list[0] = 128'd0; a_list[1] = 128'd10000; a_list[2] = 128'(DEPTH - 2); a_list[3] = 128'd5000;
    for (int i = 0; i < 4; i++) begin
      addr = a_list[i]; vf = 1'b1;
      sb.push_back(model_read(a_list[i], 1'b1));
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (rd !== exp_v) begin
        failures++;
        $display("FAIL write_disable addr=%0h got=%h exp=%h", a_list[i], rd, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    addr = 128'd5; vf = 1'b1; wd = {32'hA, 32'hB, 32'hC, 32'hD}; we = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    #1;
    addr = 128'd0; vf = 1'b1;
    sb.push_back(128'd0);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL reset_now_addr0 got=%h exp=%h", rd, exp_v);
    end
    addr = 128'd10000; vf = 1'b0;
    sb.push_back(128'd0);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL reset_now_addr10000 got=%h exp=%h", rd, exp_v);
    end
    // Write held high across edges while reset is low must be dropped.
    addr = 128'd5; vf = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    sb.push_back(128'd0);
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL reset_write_suppressed got=%h exp=%h", rd, exp_v);
    end
    @(negedge clk);
    addr = 128'd20; vf = 1'b1; wd = {32'h44, 32'h33, 32'h22, 32'h11}; we = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    m_mem[20] = 32'h11; m_mem[21] = 32'h22; m_mem[22] = 32'h33; m_mem[23] = 32'h44;
    #1;
    we = 1'b0;
    sb.push_back({32'h44, 32'h33, 32'h22, 32'h11});
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL first_write_after_reset got=%h exp=%h", rd, exp_v);
    end
    addr = 128'd0;
    sb.push_back(model_read(128'd0, 1'b1));
    #1;
    exp_v = sb.pop_front();
    checks++;
    if (rd !== exp_v) begin
      failures++;
      $display("FAIL after_reset_addr0 got=%h exp=%h", rd, exp_v);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    we = 1'b0; vf = 1'b0; addr = '0; wd = '0;
    rst = 1'b1;
    model_clear();
    #3 rst = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_vector();
    test_scalar();
    test_scalar_of_vector();
    test_wrap();
    test_back_to_back();
    test_write_disable();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
